// File: rtl/packet_receiver.sv
// packet_receiver: RGMII receive-side frame parser.
// Locks onto preamble/SFD, runs a reflected CRC-32 over the frame, holds the
// last five bytes in a delay line so the FCS can be stripped, and emits the
// payload (dest MAC onward) with sof/eof delimiters and a good/bad verdict.
// Optional destination-address filter: define PACKET_RECEIVER_MAC_FILTER_EN.
module packet_receiver #(
  parameter int          MIN_LEN  = 64,
  parameter int          MAX_LEN  = 1522,
  parameter logic [47:0] MAC_ADDR = 48'h020000000001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic [1:0]  rx_ctl,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_good,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_bad
);

`ifdef PACKET_RECEIVER_MAC_FILTER_EN
  localparam logic FILTER_EN = 1'b1;
`else
  localparam logic FILTER_EN = 1'b0;
`endif

  localparam logic [10:0] MIN_L       = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L       = 11'(MAX_LEN);
  localparam logic [10:0] DLY_DEPTH   = 11'd5;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t      state, state_n;
  logic        rx_dv, rx_er;
  logic [31:0] crc;
  logic [10:0] len;
  logic [7:0]  dly [0:4];
  logic        sof_sent;
  logic        match_uc, match_bc;

  // next-cycle output values and datapath strobes from the FSM
  logic        nxt_valid, nxt_sof, nxt_eof, nxt_good;
  logic [7:0]  nxt_data;
  logic        inc_ok, inc_bad, start, accept;
  logic [7:0]  mac_byte;
  logic        uc_hit, bc_hit, crc_ok, len_ok;

  assign rx_dv = rx_ctl[0];
  assign rx_er = rx_ctl[0] ^ rx_ctl[1];

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // station-address byte expected at the current frame position
  always_comb begin
    mac_byte = '0;
    case (len[2:0])
      3'd0: mac_byte = MAC_ADDR[47:40];
      3'd1: mac_byte = MAC_ADDR[39:32];
      3'd2: mac_byte = MAC_ADDR[31:24];
      3'd3: mac_byte = MAC_ADDR[23:16];
      3'd4: mac_byte = MAC_ADDR[15:8];
      3'd5: mac_byte = MAC_ADDR[7:0];
      default: mac_byte = '0;
    endcase
    uc_hit = match_uc && (rx_data == mac_byte);
    bc_hit = match_bc && (rx_data == 8'hFF);
    crc_ok = (crc == CRC_RESIDUE);
    len_ok = (len >= MIN_L) && (len <= MAX_L);
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= DROP;
    else       state <= state_n;
  end

  // next-state and per-cycle emit decisions
  always_comb begin
    state_n   = state;
    nxt_valid = 1'b0;
    nxt_sof   = 1'b0;
    nxt_eof   = 1'b0;
    nxt_good  = 1'b0;
    nxt_data  = '0;
    inc_ok    = 1'b0;
    inc_bad   = 1'b0;
    start     = 1'b0;
    accept    = 1'b0;
    case (state)
      DROP: begin
        if (!rx_dv) state_n = IDLE;
      end
      IDLE: begin
        if (rx_dv) state_n = (!rx_er && rx_data == 8'h55) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!rx_dv)                 state_n = IDLE;
        else if (rx_er)             state_n = DROP;
        else if (rx_data == 8'hD5) begin
          state_n = DATA;
          start   = 1'b1;
        end
        else if (rx_data != 8'h55)  state_n = DROP;
      end
      DATA: begin
        // error and over-length share one path; rx_er wins over end-of-frame
        if (rx_er || (rx_dv && len == MAX_L)) begin
          if (sof_sent) begin
            nxt_valid = 1'b1;
            nxt_eof   = 1'b1;
          end
          inc_bad = 1'b1;
          state_n = DROP;
        end
        else if (!rx_dv) begin
          if (len >= DLY_DEPTH) begin
            nxt_valid = 1'b1;
            nxt_sof   = !sof_sent;
            nxt_eof   = 1'b1;
            nxt_good  = crc_ok && len_ok;
            nxt_data  = dly[4];
            inc_ok    = crc_ok && len_ok;
            inc_bad   = !(crc_ok && len_ok);
          end
          else begin
            inc_bad = 1'b1;
          end
          state_n = IDLE;
        end
        else begin
          accept = 1'b1;
          if (len >= DLY_DEPTH) begin
            if (FILTER_EN && len == DLY_DEPTH && !(uc_hit || bc_hit)) begin
              state_n = DROP;
            end
            else begin
              nxt_valid = 1'b1;
              nxt_sof   = !sof_sent;
              nxt_data  = dly[4];
            end
          end
        end
      end
      default: state_n = DROP;
    endcase
  end

  // registered outputs, counters, CRC, length and delay line
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_good   <= 1'b0;
      frames_ok  <= '0;
      frames_bad <= '0;
      crc        <= '0;
      len        <= '0;
      sof_sent   <= 1'b0;
      match_uc   <= 1'b0;
      match_bc   <= 1'b0;
      for (int unsigned i = 0; i < 5; i++) dly[i] <= '0;
    end
    else begin
      out_data  <= nxt_data;
      out_valid <= nxt_valid;
      out_sof   <= nxt_sof;
      out_eof   <= nxt_eof;
      out_good  <= nxt_good;
      if (inc_ok)  frames_ok  <= frames_ok + 16'd1;
      if (inc_bad) frames_bad <= frames_bad + 16'd1;
      if (start) begin
        crc      <= '1;
        len      <= '0;
        sof_sent <= 1'b0;
        match_uc <= 1'b1;
        match_bc <= 1'b1;
      end
      else if (accept) begin
        crc <= crc_next(crc, rx_data);
        if (len != '1) len <= len + 11'd1;
        dly[0] <= rx_data;
        for (int unsigned i = 1; i < 5; i++) dly[i] <= dly[i-1];
        if (len < 11'd6) begin
          match_uc <= uc_hit;
          match_bc <= bc_hit;
        end
      end
      if (nxt_sof) sof_sent <= 1'b1;
    end
  end

endmodule

// File: tb/tb_packet_receiver.sv
// tb_packet_receiver: directed frame-level vectors for packet_receiver.
// Each table record describes one frame and the output it must produce;
// hand-written sequences cover reset, carrier indication and preamble errors.
module tb_packet_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic [1:0]  rx_ctl;
  logic [7:0]  out_data;
  logic        out_valid, out_sof, out_eof, out_good;
  logic [15:0] frames_ok, frames_bad;

  always #5 clk = ~clk;

  packet_receiver dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_ctl     (rx_ctl),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .out_good   (out_good),
    .frames_ok  (frames_ok),
    .frames_bad (frames_bad)
  );

  localparam logic [47:0] STATION = 48'h020000000001;
  localparam logic [47:0] BCAST   = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] OTHER   = 48'h020000000002;

  int vectors     = 0;
  int miscompares = 0;
  int exp_ok      = 0;
  int exp_bad     = 0;

  logic [7:0] frame [0:1599];

  // output monitor state
  logic [7:0] cap [0:2047];
  int   n_valid, n_sof, sof_idx, n_eof, eof_idx;
  logic eof_good;

  typedef struct {
    int len;
    int dest;       // 0 station, 1 broadcast, 2 other
    bit bad_fcs;
    int err_at;     // -1: no rx_er
    int exp_valid;
    bit exp_eof;
    bit exp_good;
    bit zero_last;  // terminating eof carries 0x00 (error path)
    int d_ok;
    int d_bad;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];

  always @(negedge clk) begin
    if (out_valid) begin
      if (n_valid < 2048) cap[n_valid] = out_data;
      if (out_sof) begin
        n_sof++;
        sof_idx = n_valid;
      end
      if (out_eof) begin
        n_eof++;
        eof_idx  = n_valid;
        eof_good = out_good;
      end
      n_valid++;
    end
  end

  task automatic clear_mon();
    n_valid  = 0;
    n_sof    = 0;
    sof_idx  = -1;
    n_eof    = 0;
    eof_idx  = -1;
    eof_good = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_gen(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build(input int len, input int dest, input bit bad_fcs);
    logic [47:0] m;
    logic [31:0] c;
    m = (dest == 0) ? STATION : (dest == 1) ? BCAST : OTHER;
    for (int k = 0; k < len; k++)
      frame[k] = (k < 6) ? m[8*(5-k) +: 8] : 8'((k * 7 + 3) & 255);
    c = 32'hFFFFFFFF;
    for (int k = 0; k < len - 4; k++) c = crc_gen(c, frame[k]);
    c = ~c;
    if (len >= 4)
      for (int k = 0; k < 4; k++) frame[len-4+k] = c[8*k +: 8];
    if (bad_fcs) frame[len-1] = frame[len-1] ^ 8'h01;
  endtask

  task automatic step(input logic [1:0] ctl, input logic [7:0] d);
    rx_ctl  = ctl;
    rx_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int len, input int err_at);
    for (int k = 0; k < 7; k++) step(2'b11, 8'h55);
    step(2'b11, 8'hD5);
    for (int k = 0; k < len; k++) step((k == err_at) ? 2'b01 : 2'b11, frame[k]);
    repeat (4) step(2'b00, 8'h00);
  endtask

  task automatic check_result(input string tag, input int ev, input bit eof,
                              input bit good, input bit zero_last);
    int   bad;
    logic [7:0] want;
    check({tag, "_nvalid"}, n_valid, ev);
    check({tag, "_nsof"}, n_sof, (ev > 0) ? 1 : 0);
    if (ev > 0) check({tag, "_sofidx"}, sof_idx, 0);
    check({tag, "_neof"}, n_eof, eof ? 1 : 0);
    if (eof) begin
      check({tag, "_eofidx"}, eof_idx, ev - 1);
      check({tag, "_good"}, int'(eof_good), int'(good));
    end
    bad = 0;
    for (int i = 0; i < n_valid && i < 2048; i++) begin
      want = (zero_last && i == n_valid - 1) ? 8'h00 : frame[i];
      if (cap[i] !== want) bad++;
    end
    check({tag, "_data"}, bad, 0);
    check({tag, "_frames_ok"}, int'(frames_ok), exp_ok & 16'hFFFF);
    check({tag, "_frames_bad"}, int'(frames_bad), exp_bad & 16'hFFFF);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_sof"}, int'(out_sof), 0);
    check({tag, "_eof"}, int'(out_eof), 0);
    check({tag, "_good"}, int'(out_good), 0);
    check({tag, "_data"}, int'(out_data), 0);
    check({tag, "_frames_ok"}, int'(frames_ok), 0);
    check({tag, "_frames_bad"}, int'(frames_bad), 0);
  endtask

  initial begin
    //           len  dst fcs err  valid eof good zero ok bad
    tbl[0] = '{  64,  0,  0,  -1,   60,  1,  1,   0,  1, 0};  // good minimum
    tbl[1] = '{  64,  0,  1,  -1,   60,  1,  0,   0,  0, 1};  // FCS bit flipped
    tbl[2] = '{  64,  0,  0,  20,   16,  1,  0,   1,  0, 1};  // rx_er on byte 20
    tbl[3] = '{  40,  0,  0,  -1,   36,  1,  0,   0,  0, 1};  // runt, CRC ok
    tbl[4] = '{   4,  0,  0,  -1,    0,  0,  0,   0,  0, 1};  // too short to emit
    tbl[5] = '{   5,  0,  0,  -1,    1,  1,  0,   0,  0, 1};  // single byte sof+eof
    tbl[6] = '{  63,  0,  0,  -1,   59,  1,  0,   0,  0, 1};  // MIN_LEN-1
    tbl[7] = '{1522,  0,  0,  -1, 1518,  1,  1,   0,  1, 0};  // MAX_LEN
    tbl[8] = '{1600,  0,  0,  -1, 1518,  1,  0,   1,  0, 1};  // over-length
    tbl[9] = '{  64,  1,  0,  -1,   60,  1,  1,   0,  1, 0};  // broadcast
`ifdef PACKET_RECEIVER_MAC_FILTER_EN
    tbl[10] = '{ 64,  2,  0,  -1,    0,  0,  0,   0,  0, 0};  // foreign dest filtered
`else
    tbl[10] = '{ 64,  2,  0,  -1,   60,  1,  1,   0,  1, 0};  // foreign dest accepted
`endif

    clear_mon();
    reset   = 1'b1;
    rx_ctl  = 2'b00;
    rx_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) step(2'b00, 8'h00);

    for (int i = 0; i < NV; i++) begin
      build(tbl[i].len, tbl[i].dest, tbl[i].bad_fcs);
      clear_mon();
      send(tbl[i].len, tbl[i].err_at);
      exp_ok  += tbl[i].d_ok;
      exp_bad += tbl[i].d_bad;
      check_result($sformatf("vec%0d", i), tbl[i].exp_valid, tbl[i].exp_eof,
                   tbl[i].exp_good, tbl[i].zero_last);
    end

    // carrier indication while idle is ignored; the next frame still syncs
    build(64, 0, 0);
    clear_mon();
    repeat (3) step(2'b10, 8'h0F);
    send(64, -1);
    exp_ok += 1;
    check_result("carrier", 60, 1, 1, 0);

    // corrupted preamble: everything up to the gap is dropped, nothing counted
    clear_mon();
    repeat (2) step(2'b11, 8'h55);
    step(2'b11, 8'h12);
    step(2'b11, 8'hD5);
    for (int k = 0; k < 20; k++) step(2'b11, frame[k]);
    repeat (4) step(2'b00, 8'h00);
    check_result("preamble_glitch", 0, 0, 0, 0);

    // reset pulsed mid-frame, then a clean frame
    build(64, 0, 0);
    for (int k = 0; k < 7; k++) step(2'b11, 8'h55);
    step(2'b11, 8'hD5);
    for (int k = 0; k < 30; k++) step(2'b11, frame[k]);
    reset = 1'b1;
    step(2'b11, frame[30]);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check_all_zero("midreset");
    clear_mon();
    for (int k = 31; k < 64; k++) step(2'b11, frame[k]);
    repeat (4) step(2'b00, 8'h00);
    exp_ok  = 0;
    exp_bad = 0;
    check_result("after_reset_tail", 0, 0, 0, 0);
    clear_mon();
    send(64, -1);
    exp_ok += 1;
    check_result("after_reset_good", 60, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/packet_receiver.md
Name: packet_receiver

Overview:
- Receive-side counterpart of packet_streamer: takes the demuxed RGMII receive byte stream from the Ethernet PHY (phy_rx_demux_data / phy_rx_demux_ctl).
- Finds preamble/SFD, strips the FCS and checks CRC-32 and length, then emits payload bytes (dest MAC onward) with frame delimiters and a good/bad verdict.
- Feeds a future command/config path to the housekeeping CPU; instantiated in the phy_rx_clk domain.

Parameters:
- MIN_LEN, 64, minimum frame length in bytes, dest MAC through FCS inclusive.
- MAX_LEN, 1522, maximum frame length in bytes, same basis.
- MAC_ADDR, 48'h020000000001, station address; used only with the optional feature.

Ports:
- clk  in  1  receive byte clock (phy_rx_clk at the top level)
- reset  in  1  synchronous, active-high
- rx_data  in  8  received byte (phy_rx_demux_data)
- rx_ctl  in  2  demuxed RX_CTL; rx_dv = rx_ctl[0], rx_er = rx_ctl[0]^rx_ctl[1]
- out_data  out  8  payload byte
- out_valid  out  1  out_data valid this cycle
- out_sof  out  1  first byte of frame (qualified by out_valid)
- out_eof  out  1  last byte of frame (qualified by out_valid)
- out_good  out  1  frame verdict; meaningful only with out_eof
- frames_ok  out  16  count of good frames, wraps
- frames_bad  out  16  count of bad frames, wraps

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- All outputs are registered. Reset drives every output and both counters to 0, clears the CRC, length counter and delay line, and enters DROP.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- DROP: leave for IDLE on the first cycle with rx_dv=0. This guarantees no sync onto a partial frame after reset or an error.
- IDLE:
  - rx_dv=1, rx_er=0, byte 0x55 -> PREAMBLE.
  - Any other rx_dv=1 cycle -> DROP.
  - rx_dv=0 with rx_er=1 (carrier indication) is ignored.
- PREAMBLE:
  - 0x55 -> stay.
  - 0xD5 -> DATA, with CRC initialised to 0xFFFFFFFF and length counter L=0.
  - Other byte or rx_er=1 -> DROP.
  - rx_dv=0 -> IDLE.
  - Nothing is counted in these cases.
- CRC: reflected CRC-32, LSB-first, polynomial 0xEDB88320, updated on every DATA byte including the FCS. Frame CRC passes iff the register equals 0xDEBB20E3 after the last byte.
- Delay line: 5-byte shift register. Each DATA byte is shifted in; once 5 bytes are held, the oldest byte is emitted on the next cycle (out_valid=1).
  - The first emitted byte carries out_sof=1.
  - L is an 11-bit counter that saturates at 2047.
- End of frame (rx_dv falls in DATA):
  - L>=5: emit the remaining oldest byte (the last payload byte) with out_eof=1 and out_good = CRC pass & MIN_LEN<=L<=MAX_LEN. The 4 FCS bytes are discarded. Increment frames_ok or frames_bad. Go to IDLE.
  - L=5 emits a single byte with sof=eof=1, good=0.
  - L<5: nothing is emitted; frames_bad increments.
- rx_er=1 in DATA, or the byte that would make L>MAX_LEN:
  - If sof has already been emitted, the next cycle emits out_valid=1, out_eof=1, out_good=0, out_data=0x00.
  - frames_bad increments; go to DROP.
  - Invariant: out_eof is emitted iff out_sof was emitted for that frame.
- Latency: byte k of the frame appears on out_data one cycle after byte k+5 is sampled. The last payload byte appears one cycle after rx_dv falls.
- Bytes arrive every clock during rx_dv; there is no backpressure, so the downstream must accept every out_valid.
- Simultaneous events:
  - rx_er takes priority over end-of-frame and over the length check.
  - A counter increment and its wrap occur in the same cycle.
  - reset overrides everything.

Optional Feature:
- PACKET_RECEIVER_MAC_FILTER_EN defined:
  - A running match flag compares bytes 0-5 against MAC_ADDR and against ff:ff:ff:ff:ff:ff.
  - The decision is made at the arrival of byte 5, before byte 0 is emitted.
  - On mismatch: go to DROP, emit nothing, increment neither counter.
- Undefined: all frames are accepted; MAC_ADDR is unused.

Test Plan:
- Good 64-byte frame (7x0x55, 0xD5, 60 data bytes, valid FCS) -> exactly 60 out_valid bytes matching the input; sof on byte 0; eof+good=1 on byte 59; frames_ok=1.
- Same frame with one FCS bit flipped -> 60 bytes emitted, eof with good=0, frames_bad=1, frames_ok unchanged.
- rx_er asserted on data byte 20 -> sof seen; eof, good=0, data 0x00 on the next cycle; nothing further emitted until rx_dv=0 and a new preamble arrives; frames_bad=1.
- Runt frame of 40 bytes with valid CRC -> 36 bytes emitted, eof good=0. A 4-byte frame -> no output, frames_bad increments. A 1600-byte frame -> eof good=0 after 1517 emitted bytes, then DROP.
- Reset pulsed mid-frame -> all outputs 0 the next cycle; remaining bytes of that frame produce no output; the following good frame is received normally.
- With PACKET_RECEIVER_MAC_FILTER_EN: frame to MAC_ADDR -> received; broadcast -> received; dest 02:00:00:00:00:02 -> no output and counters unchanged.
